pbs_turn_ctrl: RTL and testbench
================================

Name: pbs_turn_ctrl

Overview:
- Turn-sequencing controller driving the battle datapath's control inputs: actr, target, app_dmg, stop and datapath reset.
- Alternates player and AI turns, waits for the move-mux and damage register pipeline to settle, pulses damage application, then checks for knockout.
- Sits between the button/switch front-end and the datapath; reads HP, dmg and accu back from it.

Parameters:
- HP_W, 5, width of HP/dmg/accu buses.
- SETTLE, 2, cycles from actr change until dmg/accu outputs are valid (trainer mux register plus output register).
- ROLL_CYCLES, 8, cycles RNG runs (stop=0) before being frozen for the AI pick.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- go  in  1  player confirm button; already synchronised, level; block edge-detects it internally.
- p_hp  in  HP_W  player HP from datapath.
- ai_hp  in  HP_W  AI HP from datapath.
- accu  in  HP_W  current move accuracy from datapath (used only with MISS_CHECK_EN).
- acc_roll  in  HP_W  frozen accuracy RNG value (used only with MISS_CHECK_EN).
- actr  out  1  0 = player move selected, 1 = AI RNG move.
- target  out  1  0 = damage the player, 1 = damage the AI.
- app_dmg  out  1  single-cycle apply pulse.
- stop  out  1  1 freezes the RNG oscillators.
- dp_rst_n  out  1  active-low datapath reset.
- busy  out  1  high outside IDLE, P_WAIT, WIN and LOSE.
- game_over  out  1  high in WIN or LOSE.
- winner  out  1  0 = player, 1 = AI; valid while game_over.
- miss  out  1  last attack missed; held until the next apply.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - Outputs: actr=0, target=1, app_dmg=0, stop=1, dp_rst_n=0, busy=0, game_over=0, winner=0, miss=0.
  - The go edge-detect register is cleared.
  - Reset mid-turn aborts the turn immediately, with no app_dmg.
- go_rise = go high this cycle and low last cycle; exactly one event per press.
- State machine (dp_rst_n=1 in every state except IDLE):
  - IDLE: dp_rst_n=0, stop=1. On go_rise go to P_WAIT.
  - P_WAIT: actr=0, stop=0 (RNG free-runs). On go_rise go to P_SETTLE and load the counter with SETTLE.
  - P_SETTLE: actr=0, target=1. Counter decrements; at 0 go to P_APPLY.
  - P_APPLY: target=1, app_dmg=1 for exactly this cycle. Go to P_CHECK.
  - P_CHECK: one cycle for the HP register to update. If ai_hp==0 go to WIN; else go to AI_ROLL and load the counter with ROLL_CYCLES.
  - AI_ROLL: stop=0. Counter decrements; at 0 go to AI_FREEZE.
  - AI_FREEZE: stop=1, actr=1. Load the counter with SETTLE and go to AI_SETTLE.
  - AI_SETTLE: actr=1, target=0, stop=1. Counter decrements; at 0 go to AI_APPLY.
  - AI_APPLY: target=0, app_dmg=1 for one cycle. Go to AI_CHECK.
  - AI_CHECK: if p_hp==0 go to LOSE; else go to P_WAIT.
  - WIN: winner=0, game_over=1, stop=1.
  - LOSE: winner=1, game_over=1, stop=1.
  - From WIN or LOSE, go_rise goes to IDLE.
- Rules and boundary conditions:
  - go_rise in any state other than IDLE, P_WAIT, WIN or LOSE is ignored.
  - Both HP checks compare with ==0 only; the datapath saturates at 0.
  - AI_CHECK is reached only after P_CHECK has passed, so simultaneous KO cannot occur; the player's attack has priority.
  - Latency from go_rise in P_WAIT to the player app_dmg is SETTLE+1 cycles.
  - SETTLE=0 and ROLL_CYCLES=0 are legal and skip the corresponding wait.

Optional Feature:
- Macro PBS_MISS_CHECK_EN.
- Defined:
  - In P_APPLY and AI_APPLY, app_dmg is asserted only if accu >= acc_roll (unsigned compare).
  - Otherwise app_dmg stays 0 and miss is set to 1.
  - miss clears at the next apply state that hits.
- Undefined: every apply hits, miss is tied to 0, and accu and acc_roll are unused.

Decomposition:
- Package pbs_pkg: state enum type, HP_W default, ACTR_PLAYER/ACTR_AI and TGT_PLAYER/TGT_AI constants.
- Sub-module pbs_edge_det: a one-bit rising-edge detector with synchronous active-low reset, used for go.

Test Plan:
- Reset: rst=0 for 2 cycles then 1 → IDLE; stop=1, dp_rst_n=0, app_dmg=0, game_over=0.
- Player turn: go pulse (IDLE→P_WAIT), then a second go pulse → app_dmg high exactly 3 cycles later with target=1, actr=0, for one cycle only.
- Player KO: ai_hp driven to 0 in the cycle after the player apply → WIN, winner=0, game_over=1; a further go pulse returns the block to IDLE.
- AI turn: ai_hp=7 after the player hit → stop=0 for 8 cycles, then stop=1 and actr=1; app_dmg with target=0 follows SETTLE+1 cycles after AI_FREEZE. p_hp=0 → LOSE, winner=1.
- Robustness:
  - go held high for 20 cycles → only one transition.
  - rst=0 asserted during AI_SETTLE → IDLE next cycle with no app_dmg.
- PBS_MISS_CHECK_EN defined:
  - accu=10, acc_roll=12 → no app_dmg, miss=1, turn still advances.
  - accu=12, acc_roll=12 → app_dmg pulses and miss clears to 0.

Source files
------------

// File: rtl/pbs_turn_ctrl_pkg.sv
// Shared types and constants for the battle turn controller (package pbs_pkg).
package pbs_pkg;

  localparam int HP_W_DEF = 5;

  localparam logic ACTR_PLAYER = 1'b0;
  localparam logic ACTR_AI     = 1'b1;
  localparam logic TGT_PLAYER  = 1'b0;
  localparam logic TGT_AI      = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P_WAIT,
    S_P_SETTLE,
    S_P_APPLY,
    S_P_CHECK,
    S_AI_ROLL,
    S_AI_FREEZE,
    S_AI_SETTLE,
    S_AI_APPLY,
    S_AI_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pbs_turn_ctrl_if.sv
// Control/readback bundle between the turn controller (master) and the battle datapath (slave).
interface pbs_turn_ctrl_if #(parameter int HP_W = 5);
  logic            actr;
  logic            target;
  logic            app_dmg;
  logic            stop;
  logic            dp_rst_n;
  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;
  logic [HP_W-1:0] accu;
  logic [HP_W-1:0] acc_roll;

  modport master (
    output actr, target, app_dmg, stop, dp_rst_n,
    input  p_hp, ai_hp, accu, acc_roll
  );

  modport slave (
    input  actr, target, app_dmg, stop, dp_rst_n,
    output p_hp, ai_hp, accu, acc_roll
  );
endinterface

// File: rtl/pbs_turn_ctrl_edge_det.sv
// One-bit rising-edge detector (module pbs_edge_det); one pulse per low-to-high transition.
module pbs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;

  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

  assign rise = d & ~q;
endmodule

// File: rtl/pbs_turn_ctrl.sv
// Turn sequencer for the battle datapath: player turn, AI roll/freeze, damage apply, KO check.
// Optional accuracy check enabled by defining PBS_MISS_CHECK_EN.
module pbs_turn_ctrl
  import pbs_pkg::*;
#(
  parameter int HP_W        = HP_W_DEF,
  parameter int SETTLE      = 2,
  parameter int ROLL_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  pbs_turn_ctrl_if.master   dp,
  output logic              busy,
  output logic              game_over,
  output logic              winner,
  output logic              miss
);

  localparam int CNT_MAX = max2(SETTLE, ROLL_CYCLES);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [HP_W-1:0] HP_ZERO = '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             go_rise;
  logic             apply;
  logic             hit;

  pbs_edge_det u_go_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (go),
    .rise (go_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Each wait state lasts exactly its count in cycles; a zero count skips it entirely.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    apply       = 1'b0;
    dp.actr     = ACTR_PLAYER;
    dp.target   = TGT_AI;
    dp.stop     = 1'b1;
    dp.dp_rst_n = 1'b1;
    busy        = 1'b1;
    game_over   = 1'b0;
    winner      = 1'b0;
    unique case (state)
      S_IDLE: begin
        dp.dp_rst_n = 1'b0;
        busy        = 1'b0;
        if (go_rise) state_n = S_P_WAIT;
      end
      S_P_WAIT: begin
        dp.stop = 1'b0;
        busy    = 1'b0;
        if (go_rise) begin
          state_n = (SETTLE == 0) ? S_P_APPLY : S_P_SETTLE;
          cnt_n   = CNT_W'(SETTLE);
        end
      end
      S_P_SETTLE: begin
        if (cnt <= CNT_W'(1)) state_n = S_P_APPLY;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      S_P_APPLY: begin
        apply   = 1'b1;
        state_n = S_P_CHECK;
      end
      S_P_CHECK: begin
        if (dp.ai_hp == HP_ZERO) state_n = S_WIN;
        else begin
          state_n = (ROLL_CYCLES == 0) ? S_AI_FREEZE : S_AI_ROLL;
          cnt_n   = CNT_W'(ROLL_CYCLES);
        end
      end
      S_AI_ROLL: begin
        dp.stop = 1'b0;
        if (cnt <= CNT_W'(1)) state_n = S_AI_FREEZE;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      S_AI_FREEZE: begin
        dp.actr = ACTR_AI;
        state_n = (SETTLE == 0) ? S_AI_APPLY : S_AI_SETTLE;
        cnt_n   = CNT_W'(SETTLE);
      end
      S_AI_SETTLE: begin
        dp.actr   = ACTR_AI;
        dp.target = TGT_PLAYER;
        if (cnt <= CNT_W'(1)) state_n = S_AI_APPLY;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      S_AI_APPLY: begin
        dp.actr   = ACTR_AI;
        dp.target = TGT_PLAYER;
        apply     = 1'b1;
        state_n   = S_AI_CHECK;
      end
      S_AI_CHECK: begin
        state_n = (dp.p_hp == HP_ZERO) ? S_LOSE : S_P_WAIT;
      end
      S_WIN: begin
        busy      = 1'b0;
        game_over = 1'b1;
        if (go_rise) state_n = S_IDLE;
      end
      S_LOSE: begin
        busy      = 1'b0;
        game_over = 1'b1;
        winner    = 1'b1;
        if (go_rise) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dp.app_dmg = apply & hit;

`ifdef PBS_MISS_CHECK_EN
  logic miss_q;

  assign hit = (dp.accu >= dp.acc_roll);

  // Miss flag is only re-evaluated on an apply cycle, so it survives the rest of the turn.
  always_ff @(posedge clk) begin
    if (!rst)       miss_q <= 1'b0;
    else if (apply) miss_q <= ~hit;
  end

  assign miss = miss_q;
`else
  logic unused_acc;

  assign hit        = 1'b1;
  assign miss       = 1'b0;
  assign unused_acc = ^{dp.accu, dp.acc_roll};
`endif

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed bench for pbs_turn_ctrl; a scoreboard queue holds expected app_dmg pulses.
module tb_pbs_turn_ctrl;
  import pbs_pkg::*;

  localparam int SETTLE = 2;
  localparam int ROLL   = 8;

  typedef struct {
    int   cyc;
    logic target;
    logic actr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go  = 1'b0;
  logic busy, game_over, winner, miss;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pbs_turn_ctrl_if #(.HP_W(5)) dpi ();

  pbs_turn_ctrl #(.HP_W(5), .SETTLE(SETTLE), .ROLL_CYCLES(ROLL)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .dp        (dpi),
    .busy      (busy),
    .game_over (game_over),
    .winner    (winner),
    .miss      (miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic press(output int gc);
    gc = cyc;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
  endtask

  task automatic push(input int c, input logic tgt, input logic act);
    exp_t e;
    e.cyc = c;
    e.target = tgt;
    e.actr = act;
    sb.push_back(e);
  endtask

  // Every apply pulse must match the head of the scoreboard in cycle, target and actr.
  always @(negedge clk) begin
    if (dpi.app_dmg === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_apply", cyc, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_apply_cyc", cyc, e.cyc);
        chk("sb_apply_target", dpi.target, e.target);
        chk("sb_apply_actr", dpi.actr, e.actr);
      end
    end
  end

  initial begin
    int gc;
    dpi.p_hp = 5'd31;
    dpi.ai_hp = 5'd31;
    dpi.accu = 5'd0;
    dpi.acc_roll = 5'd0;

    // Reset
    tick();
    tick();
    rst = 1'b1;
    chk("rst_stop", dpi.stop, 1'b1);
    chk("rst_dp_rst_n", dpi.dp_rst_n, 1'b0);
    chk("rst_app_dmg", dpi.app_dmg, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_actr", dpi.actr, 1'b0);
    chk("rst_target", dpi.target, 1'b1);
    chk("rst_winner", winner, 1'b0);
    chk("rst_miss", miss, 1'b0);

    // Player turn ending in KO
    press(gc);
    chk("pwait_dp_rst_n", dpi.dp_rst_n, 1'b1);
    chk("pwait_stop", dpi.stop, 1'b0);
    chk("pwait_busy", busy, 1'b0);
    push(cyc + SETTLE + 1, 1'b1, 1'b0);
    press(gc);
    chk("psettle_busy", busy, 1'b1);
    chk("psettle_stop", dpi.stop, 1'b1);
    wait_to(gc + 3);
    chk("p_apply_now", dpi.app_dmg, 1'b1);
    tick();
    dpi.ai_hp = 5'd0;
    tick();
    chk("win_game_over", game_over, 1'b1);
    chk("win_winner", winner, 1'b0);
    chk("win_busy", busy, 1'b0);
    chk("win_stop", dpi.stop, 1'b1);
    press(gc);
    chk("win_to_idle", dpi.dp_rst_n, 1'b0);
    chk("idle_game_over", game_over, 1'b0);

    // Full AI turn ending in LOSE
    dpi.ai_hp = 5'd7;
    press(gc);
    push(cyc + 3, 1'b1, 1'b0);
    push(cyc + 16, 1'b0, 1'b1);
    press(gc);
    wait_to(gc + 4);
    chk("pcheck_stop", dpi.stop, 1'b1);
    chk("pcheck_miss", miss, 1'b0);
    for (int c = gc + 5; c <= gc + 12; c++) begin
      wait_to(c);
      chk("roll_stop", dpi.stop, 1'b0);
    end
    wait_to(gc + 13);
    chk("freeze_stop", dpi.stop, 1'b1);
    chk("freeze_actr", dpi.actr, 1'b1);
    tick();
    chk("ai_settle_target", dpi.target, 1'b0);
    chk("ai_settle_actr", dpi.actr, 1'b1);
    wait_to(gc + 16);
    dpi.p_hp = 5'd0;
    wait_to(gc + 18);
    chk("lose_game_over", game_over, 1'b1);
    chk("lose_winner", winner, 1'b1);
    press(gc);
    chk("lose_to_idle", dpi.dp_rst_n, 1'b0);

    // go held high: one transition only
    dpi.p_hp = 5'd31;
    go = 1'b1;
    repeat (20) tick();
    go = 1'b0;
    tick();
    chk("hold_in_pwait_stop", dpi.stop, 1'b0);
    chk("hold_in_pwait_rst", dpi.dp_rst_n, 1'b1);
    chk("hold_in_pwait_busy", busy, 1'b0);

    // Reset during AI_SETTLE aborts with no AI apply
    push(cyc + 3, 1'b1, 1'b0);
    press(gc);
    wait_to(gc + 14);
    chk("abort_settle_actr", dpi.actr, 1'b1);
    chk("abort_settle_target", dpi.target, 1'b0);
    rst = 1'b0;
    tick();
    chk("abort_idle_rst", dpi.dp_rst_n, 1'b0);
    chk("abort_app_dmg", dpi.app_dmg, 1'b0);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (4) tick();
    chk("abort_still_idle", dpi.dp_rst_n, 1'b0);

`ifdef PBS_MISS_CHECK_EN
    // Player miss, then AI hit at equal accuracy clears miss
    press(gc);
    dpi.accu = 5'd10;
    dpi.acc_roll = 5'd12;
    push(cyc + 16, 1'b0, 1'b1);
    press(gc);
    wait_to(gc + 3);
    chk("miss_no_app_dmg", dpi.app_dmg, 1'b0);
    tick();
    chk("miss_set", miss, 1'b1);
    chk("miss_advances", busy, 1'b1);
    dpi.accu = 5'd12;
    wait_to(gc + 16);
    chk("miss_held", miss, 1'b1);
    tick();
    chk("miss_cleared", miss, 1'b0);
    wait_to(gc + 18);
    chk("miss_back_pwait", busy, 1'b0);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
